// File: rtl/fr_pkg.sv
// Shared flag definitions for the flags register and the condition logic.
// Holds flag bit indices, default sizes and the stack address-width helper.
package fr_pkg;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_LT  = 1;

    localparam int FR_WIDTH = 2;
    localparam int FR_DEPTH = 4;

    // A one-entry stack still needs a one-bit index.
    function automatic int fr_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fr_stack_if.sv
// Flag/stack bus between the sequencer side and fr_stack.
// master drives the ALU flags and active-low strobes; slave returns flags and stack status.
interface fr_stack_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] mask;
    logic             load_bar;
    logic             push_bar;
    logic             pop_bar;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output in, mask, load_bar, push_bar, pop_bar,
        input  out, count, empty, full, ovf, unf
    );

    modport slave (
        input  in, mask, load_bar, push_bar, pop_bar,
        output out, count, empty, full, ovf, unf
    );

endinterface

// File: rtl/fr_stack_mem.sv
// Save area for fr_stack: DEPTH x WIDTH register array, one write and one read port.
// Deliberately not reset; entries at or above the live count are never observed.
module fr_stack_mem #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fr_stack.sv
// Flags register with masked load and a LIFO save area for interrupt entry/return.
// Define FR_STACK_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module fr_stack
    import fr_pkg::*;
#(
    parameter int WIDTH = FR_WIDTH,
    parameter int DEPTH = FR_DEPTH
) (
    input  logic        clk,
    input  logic        reset_bar,
    fr_stack_if.slave   bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = fr_addr_width(DEPTH);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] loaded;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic             is_empty;
    logic             is_full;
    logic             do_load;
    logic             do_push;
    logic             do_pop;
    logic             push_ok;
    logic             pop_ok;

    assign do_load  = ~bus.load_bar;
    assign do_push  = ~bus.push_bar;
    assign do_pop   = ~bus.pop_bar;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // Push and pop together cancel out: the stack is left alone.
    assign push_ok  = do_push & ~do_pop & ~is_full;
    assign pop_ok   = do_pop & ~do_push & ~is_empty;

    assign loaded   = (bus.in & bus.mask) | (out_q & ~bus.mask);

    assign waddr    = AW'(count_q);
    assign raddr    = AW'(count_q - CW'(1));

    fr_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (waddr),
        .wdata (out_q),
        .raddr (raddr),
        .rdata (rd_data)
    );

    always_comb begin
        out_d   = out_q;
        count_d = count_q;
        if (pop_ok) begin
            out_d   = rd_data;
            count_d = count_q - CW'(1);
        end else begin
            if (do_load) begin
                out_d = loaded;
            end
            if (push_ok) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            out_q   <= '0;
            count_q <= '0;
        end else begin
            out_q   <= out_d;
            count_q <= count_d;
        end
    end

`ifdef FR_STACK_ERR_EN
    logic ovf_q;
    logic unf_q;
    logic push_err;
    logic pop_err;

    assign push_err = do_push & ~do_pop & is_full;
    assign pop_err  = do_pop & ~do_push & is_empty;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | push_err;
            unf_q <= unf_q | pop_err;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;
`else
    assign bus.ovf = 1'b0;
    assign bus.unf = 1'b0;
`endif

    assign bus.out   = out_q;
    assign bus.count = count_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;

endmodule

// File: doc/fr_stack.md
# fr_stack

Parametrised flags register with a LIFO save area. It holds the CPU flag bits with per-bit masked loads, and saves and restores the whole flag word on interrupt entry and return through a hardware stack of configurable depth. It sits between the ALU flag outputs and the condition/jump logic, and is driven by the sequencer's interrupt entry and return microsteps.

## Interface
Parameters:
- WIDTH, 2, number of flag bits (bit 0 = Z, bit 1 = LT at default)
- DEPTH, 4, number of saved flag words in the stack (≥1)

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset_bar  input  1  asynchronous, active-low reset
- in  input  WIDTH  new flag values from the ALU
- mask  input  WIDTH  per-bit load enable; only bits with mask=1 take `in`
- load_bar  input  1  active-low load strobe
- push_bar  input  1  active-low: save the current `out` onto the stack
- pop_bar  input  1  active-low: restore `out` from the top of the stack
- out  output  WIDTH  current flags, registered
- count  output  $clog2(DEPTH+1)  number of occupied stack entries
- empty  output  1  count==0
- full  output  1  count==DEPTH
- ovf  output  1  sticky: push attempted while full (FR_STACK_ERR_EN only)
- unf  output  1  sticky: pop attempted while empty (FR_STACK_ERR_EN only)

## Operation
- All state changes on the rising edge of clk; no change unless a strobe is low.
- Load only: out[i] <= mask[i] ? in[i] : out[i].
- Push, not full: mem[count] <= out (the pre-edge value), count+1. Combined with load: the old value is saved and the masked load applies to out in the same edge.
- Pop, not empty: out <= mem[count-1], count-1. Pop overrides any load in the same edge; the load is discarded.
- Push and pop in the same edge: stack is untouched and count is unchanged. out takes the masked load if load_bar is low, otherwise holds. This is not an error.
- Push while full: stack and count unchanged. out still takes any load. ovf <= 1 when the error feature is enabled.
- Pop while empty: out and count unchanged; any load still applies. unf <= 1 when the error feature is enabled.
- Memory contents above count are don't-care and are never driven onto out.
- mask=0 with load_bar low is a legal no-op.

## Timing
- Reset (reset_bar low, asynchronous, immediate): out=0, count=0, empty=1, full=0, ovf=0, unf=0. Stack contents are discarded logically. Reset mid-push or mid-pop aborts the operation.
- Release of reset is sampled at the next rising edge; the first operation can occur on that edge.
- Latency: one clock from strobe to out/count/empty/full/ovf/unf update. All outputs are registered, with no combinational path from inputs to outputs.
- empty and full are derived from registered count; they are valid in the same cycle as count.
- ovf and unf stay set until reset.

## Configuration
- FR_STACK_ERR_EN defined: ovf and unf registers are present and behave as above.
- Not defined: ovf and unf are tied to 0 and their registers are removed. Overflow and underflow are still ignored exactly as above, with no other behavioural difference.

## Structure
- Shared package/header fr_pkg: flag bit index constants (FLAG_Z=0, FLAG_LT=1) and default WIDTH/DEPTH localparams, reused by the condition logic.
- One sub-module, fr_stack_mem:
  - DEPTH×WIDTH register array with a write port (index count, data out) and a read port (index count-1).
  - Not reset.
  - Top level owns out, count and error flags.

## Test plan
- Reset and masked load: reset_bar pulsed low → out=00, empty=1, count=0. Then in=11, mask=01, load_bar low, one edge → out=01. No edge after the input change → out unchanged.
- Push and pop with load:
  - Starting state out=01: push plus load in=10, mask=11 → out=10, count=1, mem[0]=01.
  - Then pop with load in=11 → out=01, count=0, empty=1.
- Fill and overflow (DEPTH=4): push 4 distinct values → full=1. A fifth push with load in=11, mask=11 → count stays 4, out=11, ovf=1 (when FR_STACK_ERR_EN is defined; 0 otherwise).
- Drain order and underflow: pop 4 times → values return in reverse (LIFO) order. A fifth pop → out unchanged, count=0, unf=1 (with FR_STACK_ERR_EN).
- Simultaneous push and pop at count=2 with load in=10, mask=10 → count stays 2, out bit1 becomes 1, bit0 unchanged, no error flag set.
- Asynchronous reset mid-operation: reset_bar dropped between edges with count=3 and ovf=1 → all outputs return to reset values immediately, without a clock edge. The next pop → unf=1 and out=00.
